// File: rtl/cic_frame_scheduler_pkg.sv
// Shared types and default constants for the PDM CIC decimator frame scheduler.
package cic_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    PUSH
  } state_t;

  localparam int unsigned CIC_NUM_CH = 8;
  localparam int unsigned CIC_DECIM  = 64;
  localparam int unsigned CIC_ORDER  = 4;

  // Bit growth of an ORDER-stage CIC at the given decimation ratio, plus sign bit.
  function automatic int unsigned cic_width(input int unsigned order, input int unsigned decim);
    return order * $clog2(decim) + 1;
  endfunction

endpackage

// File: rtl/cic_frame_scheduler_decim_timer.sv
// PDM tick counter producing the frame clock and the integrator snapshot strobe.
module decim_timer #(
  parameter int unsigned DECIM = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic pdm_tick,
  output logic lr_clk,
  output logic snap
);

  localparam int unsigned TW = $clog2(DECIM);
  localparam logic [TW-1:0] LAST_TICK = TW'(DECIM - 1);
  localparam logic [TW-1:0] HALF_TICK = TW'(DECIM / 2);

  logic [TW-1:0] tick_cnt;
  logic [TW-1:0] cnt_next;

  always_comb begin
    cnt_next = (tick_cnt == LAST_TICK) ? '0 : tick_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      lr_clk   <= 1'b0;
      snap     <= 1'b0;
    end else begin
      snap <= 1'b0;
      // lr_clk follows the updated count, so it only moves on counted ticks
      if (enable && pdm_tick) begin
        tick_cnt <= cnt_next;
        lr_clk   <= (cnt_next >= HALF_TICK);
        snap     <= (tick_cnt == LAST_TICK);
      end
    end
  end

endmodule

// File: rtl/cic_frame_scheduler.sv
// Frame sequencer: walks each channel through the shared comb engine and streams results.
module cic_frame_scheduler
  import cic_pkg::*;
#(
  parameter int unsigned NUM_CH = CIC_NUM_CH,
  parameter int unsigned DECIM  = CIC_DECIM,
  parameter int unsigned WIDTH  = cic_width(CIC_ORDER, DECIM)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic                      pdm_tick,
  output logic                      snap,
  output logic                      lr_clk,
  output logic                      comb_req,
  output logic [$clog2(NUM_CH)-1:0] comb_ch,
  input  logic                      comb_ack,
  input  logic [WIDTH-1:0]          comb_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [$clog2(NUM_CH)-1:0] out_ch,
  output logic                      out_last,
  output logic                      overrun,
  output logic [7:0]                drop_cnt,
  input  logic                      clear_ovr
);

  localparam int unsigned CW = $clog2(NUM_CH);
  localparam logic [CW-1:0] LAST_CH = CW'(NUM_CH - 1);

  state_t        state;
  logic [CW-1:0] idx;

  decim_timer #(.DECIM(DECIM)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .enable   (enable),
    .pdm_tick (pdm_tick),
    .lr_clk   (lr_clk),
    .snap     (snap)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      comb_req  <= 1'b0;
      comb_ch   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      out_last  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap) begin
            state    <= REQ;
            idx      <= '0;
            comb_ch  <= '0;
            comb_req <= 1'b1;
          end
        end
        REQ: begin
          if (comb_ack) begin
            comb_req  <= 1'b0;
            out_data  <= comb_data;
            out_ch    <= idx;
            out_last  <= (idx == LAST_CH);
            out_valid <= 1'b1;
            state     <= PUSH;
          end
        end
        PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (out_last) begin
              state <= IDLE;
            end else begin
              idx      <= idx + 1'b1;
              comb_ch  <= idx + 1'b1;
              comb_req <= 1'b1;
              state    <= REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Any snap that finds a walk in flight (including its final accept cycle) loses its frame
  always_ff @(posedge clk) begin
    if (reset) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (clear_ovr) begin
      overrun  <= 1'b0;
      drop_cnt <= '0;
    end else if (snap && (state != IDLE)) begin
      overrun <= 1'b1;
      if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_cic_frame_scheduler.sv
// Directed bench for cic_frame_scheduler with a latency-configurable comb engine model.
module tb_cic_frame_scheduler;
  import cic_pkg::*;

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DECIM  = 64;
  localparam int unsigned WIDTH  = 25;

  logic             clk;
  logic             reset;
  logic             enable;
  logic             pdm_tick;
  logic             snap;
  logic             lr_clk;
  logic             comb_req;
  logic [2:0]       comb_ch;
  logic             comb_ack;
  logic [WIDTH-1:0] comb_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_ch;
  logic             out_last;
  logic             overrun;
  logic [7:0]       drop_cnt;
  logic             clear_ovr;

  int checks = 0;
  int errors = 0;

  int ack_lat   = 0;
  int data_base = 0;
  int req_age   = 0;
  int snap_count = 0;

  typedef struct {
    int ch;
    int data;
    bit last;
  } rec_t;
  rec_t got_q[$];

  cic_frame_scheduler #(
    .NUM_CH(NUM_CH),
    .DECIM (DECIM),
    .WIDTH (WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .pdm_tick  (pdm_tick),
    .snap      (snap),
    .lr_clk    (lr_clk),
    .comb_req  (comb_req),
    .comb_ch   (comb_ch),
    .comb_ack  (comb_ack),
    .comb_data (comb_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .overrun   (overrun),
    .drop_cnt  (drop_cnt),
    .clear_ovr (clear_ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comb engine model: acks after ack_lat cycles of continuous request
  always @(posedge clk) begin
    if (reset || !comb_req) req_age <= 0;
    else req_age <= req_age + 1;
  end
  assign comb_ack  = comb_req && (req_age >= ack_lat);
  assign comb_data = comb_ack ? WIDTH'(data_base + int'(comb_ch)) : '0;

  always @(negedge clk) begin
    if (snap) snap_count++;
    if (out_valid && out_ready) got_q.push_back('{int'(out_ch), int'(out_data), out_last});
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_snap(input int max_cyc, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!snap && n < max_cyc);
    if (!snap) check("snap_timeout", 32'(n), 32'(max_cyc + 1));
  endtask

  task automatic check_frame(input string tag, input int base, input int dbase);
    check({tag, "_count"}, 32'(got_q.size() - base), 32'(NUM_CH));
    if (got_q.size() >= base + NUM_CH) begin
      for (int k = 0; k < NUM_CH; k++) begin
        check({tag, "_ch"},   32'(got_q[base+k].ch),   32'(k));
        check({tag, "_data"}, 32'(got_q[base+k].data), 32'(dbase + k));
        check({tag, "_last"}, 32'(got_q[base+k].last), 32'(k == NUM_CH - 1));
      end
    end
  endtask

  initial begin
    int n;
    int base;
    int snaps0;
    int lr_moves;
    int guard;

    reset = 1'b1; enable = 1'b0; pdm_tick = 1'b0;
    out_ready = 1'b1; clear_ovr = 1'b0;
    step(); step();

    check("rst_snap",      32'(snap),      32'd0);
    check("rst_lr_clk",    32'(lr_clk),    32'd0);
    check("rst_comb_req",  32'(comb_req),  32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_overrun",   32'(overrun),   32'd0);
    check("rst_drop_cnt",  32'(drop_cnt),  32'd0);

    // Clean frame, zero-wait ack and ready
    ack_lat = 0; data_base = 'h40;
    enable = 1'b1; pdm_tick = 1'b1; reset = 1'b0;
    base = got_q.size();
    wait_snap(100, n);
    check("clean_snap_ticks", 32'(n), 32'd64);
    check("clean_req_at_snap", 32'(comb_req), 32'd0);
    step();
    check("clean_req_t2", 32'(comb_req), 32'd1);
    check("clean_ch_t2",  32'(comb_ch),  32'd0);
    for (int s = 1; s < 16; s++) step();
    check("clean_last_valid", 32'(out_valid), 32'd1);
    check("clean_last_flag",  32'(out_last),  32'd1);
    check("clean_last_ch",    32'(out_ch),    32'd7);
    step();
    check_frame("clean", base, 'h40);
    check("clean_overrun", 32'(overrun), 32'd0);

    // Comb latency of 3 cycles per request
    ack_lat = 3; data_base = 'h100;
    base = got_q.size();
    wait_snap(100, n);
    for (int s = 1; s <= 4; s++) begin
      step();
      check("lat_req_held", 32'(comb_req), 32'd1);
      check("lat_ack",      32'(comb_ack), 32'(s == 4));
    end
    step();
    check("lat_valid0", 32'(out_valid), 32'd1);
    check("lat_data0",  32'(out_data),  32'h100);
    check("lat_req_dropped", 32'(comb_req), 32'd0);
    for (int s = 0; s < 45; s++) step();
    check_frame("lat", base, 'h100);

    // Backpressure on ch 3 across the next snap
    ack_lat = 0; data_base = 'h200;
    base = got_q.size();
    wait_snap(100, n);
    guard = 0;
    while (!(out_valid && out_ch == 3) && guard < 20) begin
      step();
      guard++;
    end
    check("bp_reach_ch3", 32'(out_valid && out_ch == 3), 32'd1);
    out_ready = 1'b0;
    snaps0 = snap_count;
    for (int s = 0; s < 70; s++) step();
    check("bp_snap_emitted", 32'(snap_count - snaps0), 32'd1);
    check("bp_overrun",      32'(overrun),   32'd1);
    check("bp_drop_cnt",     32'(drop_cnt),  32'd1);
    check("bp_hold_valid",   32'(out_valid), 32'd1);
    check("bp_hold_ch",      32'(out_ch),    32'd3);
    check("bp_hold_data",    32'(out_data),  32'h203);
    out_ready = 1'b1;
    for (int s = 0; s < 20; s++) step();
    check_frame("bp", base, 'h200);

    // Saturation: walk stalls in PUSH so every snap drops
    out_ready = 1'b0;
    guard = 0;
    while (!out_valid && guard < 100) begin
      step();
      guard++;
    end
    check("sat_stalled", 32'(out_valid), 32'd1);
    clear_ovr = 1'b1; step(); clear_ovr = 1'b0;
    check("sat_clear_cnt", 32'(drop_cnt), 32'd0);
    check("sat_clear_ovr", 32'(overrun),  32'd0);
    for (int i = 0; i < 254; i++) begin
      wait_snap(100, n);
      step();
    end
    check("sat_cnt_254", 32'(drop_cnt), 32'd254);
    for (int i = 0; i < 46; i++) begin
      wait_snap(100, n);
      step();
    end
    check("sat_cnt_255", 32'(drop_cnt), 32'd255);
    check("sat_overrun", 32'(overrun),  32'd1);
    wait_snap(100, n);
    clear_ovr = 1'b1; step(); clear_ovr = 1'b0;
    check("clr_vs_drop_cnt", 32'(drop_cnt), 32'd0);
    check("clr_vs_drop_ovr", 32'(overrun),  32'd0);
    wait_snap(100, n);
    step();
    check("drop_after_clr", 32'(drop_cnt), 32'd1);

    // Enable gating at count 20
    out_ready = 1'b1;
    reset = 1'b1; step();
    check("rst2_drop_cnt", 32'(drop_cnt), 32'd0);
    check("rst2_overrun",  32'(overrun),  32'd0);
    reset = 1'b0;
    for (int s = 0; s < 20; s++) step();
    check("en_cnt_20", 32'(dut.u_timer.tick_cnt), 32'd20);
    enable = 1'b0;
    snaps0 = snap_count;
    lr_moves = 0;
    for (int s = 0; s < 100; s++) begin
      step();
      if (lr_clk !== 1'b0) lr_moves++;
    end
    check("en_frozen_cnt", 32'(dut.u_timer.tick_cnt), 32'd20);
    check("en_no_snap",    32'(snap_count - snaps0), 32'd0);
    check("en_lr_steady",  32'(lr_moves), 32'd0);
    enable = 1'b1;
    for (int s = 0; s < 12; s++) step();
    check("en_lr_rise", 32'(lr_clk), 32'd1);
    wait_snap(100, n);
    check("en_resume_ticks", 32'(n + 12), 32'd44);
    check("en_lr_fall_at_snap", 32'(lr_clk), 32'd0);

    // Reset during PUSH of ch 5
    guard = 0;
    while (!(out_valid && out_ch == 5) && guard < 30) begin
      step();
      guard++;
    end
    check("rstw_reach_ch5", 32'(out_valid && out_ch == 5), 32'd1);
    reset = 1'b1; step();
    check("rstw_valid",    32'(out_valid), 32'd0);
    check("rstw_data",     32'(out_data),  32'd0);
    check("rstw_ch",       32'(out_ch),    32'd0);
    check("rstw_last",     32'(out_last),  32'd0);
    check("rstw_comb_req", 32'(comb_req),  32'd0);
    check("rstw_comb_ch",  32'(comb_ch),   32'd0);
    check("rstw_lr_clk",   32'(lr_clk),    32'd0);
    check("rstw_state",    32'(dut.state), 32'(IDLE));
    reset = 1'b0;
    data_base = 'h300;
    base = got_q.size();
    wait_snap(100, n);
    check("rstw_snap_ticks", 32'(n), 32'd64);
    check("rstw_no_partial", 32'(got_q.size() - base), 32'd0);
    guard = 0;
    while (got_q.size() == base && guard < 10) begin
      step();
      guard++;
    end
    check("rstw_first_out", 32'(got_q.size() > base), 32'd1);
    if (got_q.size() > base) begin
      check("rstw_first_ch",   32'(got_q[base].ch),   32'd0);
      check("rstw_first_data", 32'(got_q[base].data), 32'h300);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_frame_scheduler.md
# cic_frame_scheduler

Sequencing controller for the multi-microphone PDM CIC decimator. Counts PDM bit ticks, issues the decimation snapshot strobe and the 48 kHz `lr_clk` frame clock, then walks every channel through the single shared comb engine with a req/ack handshake. It streams the decimated samples out with valid/ready, and flags frames that it has to drop. It sits between the per-channel integrator bank and the I2S/sample FIFO.

## Interface
- `NUM_CH`, default 8: microphone channels sharing one comb engine.
- `DECIM`, default 64: decimation ratio, i.e. PDM ticks per output frame (3.072 MHz / 48 kHz). Must be an even power of two and ≥ 2·NUM_CH+2.
- `WIDTH`, default 25: comb output width (ORDER·log2(DECIM)+1 with ORDER=4).
- `clk` in 1: system clock; one clock; all logic on rising edge.
- `reset` in 1: synchronous, active-high.
- `enable` in 1: 0 = hold the decimation counter and start no new walks.
- `pdm_tick` in 1: one-cycle strobe per PDM bit.
- `snap` out 1: one-cycle pulse; the integrator bank captures its outputs into snapshot registers.
- `lr_clk` out 1: frame clock, 50 % duty, period DECIM ticks.
- `comb_req` out 1: request to the comb engine.
- `comb_ch` out $clog2(NUM_CH): channel being requested.
- `comb_ack` in 1: comb engine has finished.
- `comb_data` in WIDTH: comb result, valid while `comb_ack` is high.
- `out_valid` out 1, `out_ready` in 1: output handshake.
- `out_data` out WIDTH: decimated sample.
- `out_ch` out $clog2(NUM_CH): channel of the sample.
- `out_last` out 1: marks the last channel of a frame.
- `overrun` out 1: sticky; a frame was dropped.
- `drop_cnt` out 8: count of dropped frames, saturating at 255.
- `clear_ovr` in 1: clears `overrun` and `drop_cnt`.

## Operation
- **Reset values:** all outputs 0, `tick_cnt`=0, FSM in IDLE.
- **Tick counter:** `tick_cnt` increments on `pdm_tick` while `enable` is high, and wraps at DECIM−1 → 0.
  - `lr_clk` is registered: 1 when the updated count ≥ DECIM/2, else 0.
  - The wrap registers `snap`=1 for exactly one cycle.
  - With `enable` low, the count holds and `snap` stays 0.
  - `lr_clk` holds its last value while `enable` is low.
- **FSM states:** IDLE, REQ, PUSH.
  - IDLE → REQ on `snap`, with channel index = 0 and `comb_ch` = index.
  - REQ: `comb_req` is held high until `comb_ack` is sampled high. `comb_ack` may be high in the first REQ cycle.
  - On ack: capture `comb_data` into the output register and go to PUSH. `comb_req` drops in the next cycle.
  - PUSH: `out_valid` is high and `out_data`, `out_ch`, `out_last` are stable until `out_ready` is sampled high.
  - `out_last` = 1 when index == NUM_CH−1.
  - On accept: if last, go to IDLE; else increment the index and go to REQ.
- **Snap while busy:** a snap arriving in REQ or PUSH is still emitted, since the integrators must stay in step. The walk in progress finishes unchanged. No new walk starts for that frame. `overrun` is set, and `drop_cnt` increments, saturating.
- **Snap in the last PUSH-accept cycle:** counts as busy, so the frame is dropped.
- **Counter clear:** `clear_ovr` has priority over a same-cycle drop; the counter ends at 0.
- **`enable` low mid-walk:** the walk completes; only new ticks and snaps stop.
- **Reset mid-walk:** all state returns to reset values on the next edge. No partial frame is emitted afterwards.

## Timing
- The `pdm_tick` that wraps the counter is at edge T. `snap` is high in cycle T+1, and `comb_req` is high from cycle T+2.
- Zero-wait ack and ready give 2 cycles per channel. A full frame then takes 2·NUM_CH cycles after `snap`+1.
- `out_valid` rises the cycle after `comb_ack` is sampled. It never drops without `out_ready`.
- `lr_clk` edges coincide with the `tick_cnt` update cycle. The `lr_clk` rising edge coincides with `snap`-phase counts; only the falling edge coincides with `snap`.

## Structure
- Package `cic_pkg` holds:
  - the state enum (IDLE/REQ/PUSH);
  - a `cic_width(order, decim)` function;
  - the default constants NUM_CH, DECIM, ORDER.
- Sub-module `decim_timer` holds `tick_cnt`, `lr_clk` and `snap` generation. The FSM, channel index and overrun logic live in the top.

## Test plan
- **Clean frame:** `pdm_tick` every cycle, ack and ready tied high → `snap` every 64 ticks, then 8 samples `out_ch` 0..7 with `out_last` only on ch 7, 16 cycles after snap+1, `overrun`=0.
- **Comb latency:** `comb_ack` delayed 3 cycles per request, `comb_data` = 0x100+ch → `comb_req` held through the wait. Outputs are 0x100..0x107 in order.
- **Backpressure:** `out_ready` low for 70 cycles during ch 3 → the next snap is emitted and that frame is dropped. `overrun`=1, `drop_cnt`=1, ch 3..7 of the first frame are still delivered intact.
- **Saturation and clear:** 300 dropped frames → `drop_cnt`=255. `clear_ovr` in the same cycle as a drop → `drop_cnt`=0 and `overrun`=0.
- **Enable gating:** `enable` low for 100 ticks at count 20 → count frozen at 20, no snap, `lr_clk` steady. Resuming gives a snap after 44 more ticks.
- **Reset mid-walk:** `reset` pulsed during PUSH of ch 5 → next cycle all outputs are 0 and FSM is IDLE. The next output is ch 0 of a new frame, 64 ticks later.
